clip_mem_sequencer: RTL and testbench
=====================================

# clip_mem_sequencer

Datapath sequencer that executes the record/play commands issued by the top-level clip controller. It turns the controller's `timer`, `memoryselect_clip_1`, `seriena` and `deseriena` levels into sample-by-sample memory writes from the deserializer or memory reads to the serializer. It returns the `seconds2` completion pulse once a full clip has been transferred. It sits between the controller, the shared two-block clip RAM and the serializer/deserializer pair.

## Interface
Parameters:
- `SAMPLE_W`, 16, audio sample width
- `OFFS_W`, 15, per-block offset width
- `CLIP_LEN`, 32000, samples per clip (2 s at 16 kHz); must satisfy 1 ≤ `CLIP_LEN` ≤ 2^`OFFS_W`

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `timer`  in  1  run request from controller, level
- `memoryselect_clip_1`  in  2  [1] block (0 = block 1, 1 = block 2); [0] direction (1 = write, 0 = read)
- `seriena`  in  1  playback enable from controller
- `deseriena`  in  1  record enable from controller
- `rx_valid`  in  1  deserializer sample strobe, one cycle per sample
- `rx_data`  in  SAMPLE_W  deserializer sample
- `tx_ready`  in  1  serializer can accept a sample
- `tx_valid`  out  1  sample offered to serializer
- `tx_data`  out  SAMPLE_W  sample to serializer
- `mem_addr`  out  OFFS_W+1  RAM address {block, offset}
- `mem_we`  out  1  RAM write strobe
- `mem_wdata`  out  SAMPLE_W  RAM write data
- `mem_rdata`  in  SAMPLE_W  RAM read data, valid one cycle after address
- `seconds2`  out  1  one-cycle pulse at clip completion
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WRITE, RD_REQ, RD_WAIT, RD_PRESENT, DONE.
- IDLE → WRITE: `timer` & `deseriena` & `memoryselect_clip_1[0]` & `armed`.
- IDLE → RD_REQ: `timer` & `seriena` & !`memoryselect_clip_1[0]` & `armed`.
- On either start, latch the block bit and clear the offset. Any other combination, including both enables set, keeps the block in IDLE.
- `armed` is cleared on entering DONE and set whenever `timer` is sampled 0, so one command produces exactly one clip. `armed` is 1 out of reset.
- WRITE:
  - Each `rx_valid` registers `rx_data` into `mem_wdata` and the address {block, offset}. `mem_we` is asserted the following cycle, then offset++.
  - After write number `CLIP_LEN`, go to DONE.
  - `rx_valid` in other states is ignored.
- Read sequence:
  - RD_REQ drives {block, offset} → RD_WAIT.
  - RD_WAIT captures `mem_rdata` into `tx_data` → RD_PRESENT.
  - RD_PRESENT holds `tx_valid`=1 and `tx_data` stable until `tx_valid`&`tx_ready`. On that handshake, offset++. Go to DONE if that was sample `CLIP_LEN`, else RD_REQ.
- DONE: `seconds2`=1 for exactly one cycle → IDLE.
- Abort: `timer`=0 in any non-IDLE, non-DONE state → IDLE next edge.
  - No `seconds2`; `tx_valid` drops; offset clears.
  - A write already registered still completes its `mem_we` cycle.
- Offset never wraps. The terminal count is compared against `CLIP_LEN`-1 and the offset width is `OFFS_W` bits.
- Block bit is latched at start; changes to `memoryselect_clip_1` mid-clip are ignored.

## Timing
- Reset (async assert): state IDLE, offset 0, `armed`=1. `tx_valid`, `mem_we`, `seconds2`, `busy`=0; `tx_data`, `mem_wdata`, `mem_addr`=0.
- Reset deassertion takes effect on the next `clock` edge.
- Start: command sampled at edge k; `busy`=1 from cycle k+1.
- Write latency: `rx_valid` sampled at edge k → `mem_we`=1 in cycle k+1. Back-to-back `rx_valid` every cycle is supported.
- Read latency: RD_REQ at cycle k → `tx_valid`=1 at k+2. Minimum 3 cycles per sample when `tx_ready` is held high.
- `seconds2` is asserted in the cycle after the final `mem_we` or final handshake.
- `rx_valid` on the cycle the final write is registered is the last one accepted.
- Simultaneous abort and final handshake: abort wins and `seconds2` is not issued.

## Structure
- `clip_pkg`: state enum, memsel bit indices (`MS_BLOCK`=1, `MS_WRITE`=0), default `CLIP_LEN`/`OFFS_W`.
- Sub-module `clip_offset_counter`: clear, increment, async reset, terminal-count flag at `CLIP_LEN`-1.
- Top FSM, datapath registers and handshake logic live in `clip_mem_sequencer`.

## Test plan
All scenarios use `CLIP_LEN`=4.
- Record block 2:
  - Stimulus: `memoryselect_clip_1`=2'b11, `deseriena`=1, `timer`=1, then 4 `rx_valid` with data 0xA0..0xA3.
  - Required: writes to addresses 0x8000..0x8003 with data 0xA0..0xA3, then a single `seconds2` pulse.
- Play block 1 under stall:
  - Stimulus: preload 0x10..0x13, `memoryselect_clip_1`=2'b00, `seriena`=1, `tx_ready` low for 5 cycles per sample.
  - Required: `tx_data` 0x10..0x13, stable while stalled; `seconds2` after the 4th handshake.
- Abort mid-record:
  - Stimulus: drop `timer` after 2 writes.
  - Required: IDLE next cycle, no `seconds2`; the next record starts at offset 0.
- Re-arm:
  - Stimulus: keep `timer` high through DONE.
  - Required: no second clip starts until `timer` is seen low once.
- Async reset mid-read:
  - Stimulus: assert `reset` while `tx_valid`=1.
  - Required: all outputs 0 immediately, before the next clock edge.
- Illegal command:
  - Stimulus: `deseriena`=1 with `memoryselect_clip_1[0]`=0, or both enables set.
  - Required: stays IDLE, `busy`=0, no `mem_we`.

Source files
------------

// File: rtl/clip_pkg.sv
// rtl/clip_pkg.sv - shared types and constants for the clip memory sequencer
package clip_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_PRESENT,
    ST_DONE
  } state_t;

  // Bit positions inside memoryselect_clip_1
  localparam int MS_BLOCK = 1;
  localparam int MS_WRITE = 0;

  // Default clip geometry: 2 s at 16 kHz in a 32K-sample block
  localparam int DEFAULT_CLIP_LEN = 32000;
  localparam int DEFAULT_OFFS_W   = 15;

endpackage

// File: rtl/clip_offset_counter.sv
// rtl/clip_offset_counter.sv - per-block sample offset counter with terminal flag
module clip_offset_counter #(
  parameter int OFFS_W   = 15,
  parameter int CLIP_LEN = 32000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [OFFS_W-1:0] count,
  output logic              last
);

  localparam logic [OFFS_W-1:0] LAST_OFFS = OFFS_W'(CLIP_LEN - 1);

  // Clear wins over increment; the count saturates at the last sample so it never wraps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + OFFS_W'(1);
    end
  end

  assign last = (count == LAST_OFFS);

endmodule

// File: rtl/clip_mem_sequencer.sv
// rtl/clip_mem_sequencer.sv - record/play sequencer between clip RAM and serdes
module clip_mem_sequencer
  import clip_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int OFFS_W   = DEFAULT_OFFS_W,
  parameter int CLIP_LEN = DEFAULT_CLIP_LEN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                timer,
  input  logic [1:0]          memoryselect_clip_1,
  input  logic                seriena,
  input  logic                deseriena,
  input  logic                rx_valid,
  input  logic [SAMPLE_W-1:0] rx_data,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [SAMPLE_W-1:0] tx_data,
  output logic [OFFS_W:0]     mem_addr,
  output logic                mem_we,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic                seconds2,
  output logic                busy
);

  state_t            state;
  logic              blk;
  logic              armed;
  logic [OFFS_W-1:0] offset;
  logic              offs_last;
  logic              offs_clr;
  logic              offs_inc;
  logic              start_wr;
  logic              start_rd;
  logic              abort;

  // A command starts only when exactly one enable matches the direction bit
  assign start_wr = (state == ST_IDLE) & timer & deseriena & ~seriena &
                    memoryselect_clip_1[MS_WRITE] & armed;
  assign start_rd = (state == ST_IDLE) & timer & seriena & ~deseriena &
                    ~memoryselect_clip_1[MS_WRITE] & armed;
  assign abort    = ~timer & (state != ST_IDLE) & (state != ST_DONE);

  // The address is always the latched block plus the live offset; a write's
  // offset only advances after its mem_we cycle, so the address holds for it
  assign mem_addr = {blk, offset};

  // Offset control: clear on start or abort, advance after each write or handshake
  always_comb begin
    offs_clr = 1'b0;
    offs_inc = 1'b0;
    if (state == ST_IDLE) begin
      offs_clr = start_wr | start_rd;
    end else if (abort) begin
      offs_clr = 1'b1;
    end else if (state == ST_WRITE) begin
      offs_inc = mem_we & ~offs_last;
    end else if (state == ST_RD_PRESENT) begin
      offs_inc = tx_ready & ~offs_last;
    end
  end

  clip_offset_counter #(
    .OFFS_W   (OFFS_W),
    .CLIP_LEN (CLIP_LEN)
  ) u_offset (
    .clock (clock),
    .reset (reset),
    .clr   (offs_clr),
    .inc   (offs_inc),
    .count (offset),
    .last  (offs_last)
  );

  // Sequencer FSM with registered datapath and handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      blk       <= 1'b0;
      armed     <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      seconds2  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      seconds2 <= 1'b0;
      mem_we   <= 1'b0;
      if (!timer) begin
        armed <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            blk   <= memoryselect_clip_1[MS_BLOCK];
            state <= ST_WRITE;
            busy  <= 1'b1;
          end else if (start_rd) begin
            blk   <= memoryselect_clip_1[MS_BLOCK];
            state <= ST_RD_REQ;
            busy  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!timer) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (mem_we && offs_last) begin
            // The final write has just gone out; anything on rx_valid now is dropped
            state    <= ST_DONE;
            seconds2 <= 1'b1;
            armed    <= 1'b0;
          end else if (rx_valid) begin
            mem_wdata <= rx_data;
            mem_we    <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (!timer) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (!timer) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tx_data  <= mem_rdata;
            tx_valid <= 1'b1;
            state    <= ST_RD_PRESENT;
          end
        end
        ST_RD_PRESENT: begin
          if (!timer) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            if (offs_last) begin
              state    <= ST_DONE;
              seconds2 <= 1'b1;
              armed    <= 1'b0;
            end else begin
              state <= ST_RD_REQ;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clip_mem_sequencer.sv
// tb/tb_clip_mem_sequencer.sv - scoreboard bench for clip_mem_sequencer
module tb_clip_mem_sequencer;

  localparam int SAMPLE_W = 16;
  localparam int OFFS_W   = 15;
  localparam int CLIP_LEN = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic                clock;
  logic                reset;
  logic                timer;
  logic [1:0]          memoryselect_clip_1;
  logic                seriena;
  logic                deseriena;
  logic                rx_valid;
  logic [SAMPLE_W-1:0] rx_data;
  logic                tx_ready;
  logic                tx_valid;
  logic [SAMPLE_W-1:0] tx_data;
  logic [OFFS_W:0]     mem_addr;
  logic                mem_we;
  logic [SAMPLE_W-1:0] mem_wdata;
  logic [SAMPLE_W-1:0] mem_rdata;
  logic                seconds2;
  logic                busy;

  logic                pre_we;
  logic [15:0]         pre_addr;
  logic [15:0]         pre_data;
  logic [15:0]         ram     [0:65535];
  logic [15:0]         ref_mem [0:65535];

  wr_t         exp_wr[$];
  logic [15:0] exp_tx[$];
  int          done_pending;
  int          compared;
  int          mismatched;
  wr_t         mon_e;

  clip_mem_sequencer #(
    .SAMPLE_W (SAMPLE_W),
    .OFFS_W   (OFFS_W),
    .CLIP_LEN (CLIP_LEN)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .timer               (timer),
    .memoryselect_clip_1 (memoryselect_clip_1),
    .seriena             (seriena),
    .deseriena           (deseriena),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .tx_ready            (tx_ready),
    .tx_valid            (tx_valid),
    .tx_data             (tx_data),
    .mem_addr            (mem_addr),
    .mem_we              (mem_we),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .seconds2            (seconds2),
    .busy                (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clip RAM: one-cycle read latency, bench preload port when the DUT is not writing
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("spurious_write", mem_we, 0);
        else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", mem_addr, mon_e.addr);
          chk("wr_data", mem_wdata, mon_e.data);
        end
      end
      if (seconds2) begin
        if (done_pending == 0) chk("spurious_seconds2", seconds2, 0);
        else begin
          chk("seconds2_seen", seconds2, 1);
          done_pending--;
        end
      end
      if (tx_valid) begin
        if (exp_tx.size() == 0) chk("spurious_tx_valid", tx_valid, 0);
        else begin
          chk("tx_data", tx_data, exp_tx[0]);
          if (tx_ready) void'(exp_tx.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while ((busy || done_pending != 0) && cyc < 200) begin
      step();
      cyc++;
    end
    chk(name, (busy || done_pending != 0), 0);
  endtask

  task automatic release_cmd();
    timer = 0; seriena = 0; deseriena = 0; rx_valid = 0; tx_ready = 0;
    step();
  endtask

  // Record n_rx samples (n_rx < CLIP_LEN aborts the clip after those writes)
  task automatic do_record(input logic b, input int n_rx, input bit keep_timer,
                           input int max_gap, input bit fixed_data);
    logic [15:0] d;
    logic [15:0] a;
    memoryselect_clip_1 = {b, 1'b1}; deseriena = 1; seriena = 0; timer = 1;
    step();
    for (int i = 0; i < n_rx; i++) begin
      repeat ($urandom_range(0, max_gap)) step();
      d = fixed_data ? 16'(16'hA0 + i) : 16'($urandom);
      a = {b, 15'(i)};
      exp_wr.push_back('{addr: a, data: d});
      ref_mem[a] = d;
      if (i == CLIP_LEN - 1) done_pending++;
      rx_data = d; rx_valid = 1;
      step();
      rx_valid = 0;
    end
    if (n_rx == CLIP_LEN) begin
      wait_idle("record_done");
    end else begin
      step();
      timer = 0;
      step();
      chk("abort_busy", busy, 0);
      chk("abort_no_pending", done_pending, 0);
    end
    if (!keep_timer) release_cmd();
  endtask

  // Play a clip with stall cycles per sample (stall < 0 picks random stalls up to 4)
  task automatic do_play(input logic b, input int stall);
    int hold = 0;
    int lim;
    int cyc = 0;
    memoryselect_clip_1 = {b, 1'b0}; seriena = 1; deseriena = 0; timer = 1; tx_ready = 0;
    for (int i = 0; i < CLIP_LEN; i++) exp_tx.push_back(ref_mem[{b, 15'(i)}]);
    done_pending++;
    lim = (stall < 0) ? $urandom_range(0, 4) : stall;
    do begin
      step();
      cyc++;
      if (tx_valid) begin
        tx_ready = (hold >= lim);
        hold++;
      end else begin
        tx_ready = 0;
        if (hold != 0) lim = (stall < 0) ? $urandom_range(0, 4) : stall;
        hold = 0;
      end
    end while ((busy || done_pending != 0) && cyc < 400);
    chk("play_done", (busy || done_pending != 0), 0);
    chk("play_tx_drained", exp_tx.size(), 0);
    release_cmd();
  endtask

  initial begin
    compared = 0; mismatched = 0; done_pending = 0;
    reset = 1; timer = 0; memoryselect_clip_1 = 2'b00; seriena = 0; deseriena = 0;
    rx_valid = 0; rx_data = '0; tx_ready = 0; pre_we = 0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_seconds2", seconds2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 0;
    step();

    // Preload offsets 0..CLIP_LEN-1 of both blocks; block 1 (bit 0) gets 0x10..
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < CLIP_LEN; i++) begin
        pre_addr = {blk[0], 15'(i)};
        pre_data = (blk == 0) ? 16'(16'h10 + i) : 16'($urandom);
        ref_mem[pre_addr] = pre_data;
        pre_we = 1;
        step();
      end
    end
    pre_we = 0;

    // Illegal commands: direction mismatch or both enables
    for (int k = 0; k < 4; k++) begin
      memoryselect_clip_1 = {k[0], (k == 0 || k == 2) ? 1'b0 : 1'b1};
      deseriena = (k != 1);
      seriena   = (k >= 1);
      timer = 1;
      for (int c = 0; c < 3; c++) begin
        rx_valid = 1; rx_data = 16'($urandom);
        step();
        chk("illegal_busy", busy, 0);
      end
      release_cmd();
    end

    do_record(1'b1, CLIP_LEN, 0, 0, 1);
    do_play(1'b0, 5);

    do_record(1'b0, 2, 0, 1, 0);
    do_record(1'b0, CLIP_LEN, 0, 0, 0);
    do_play(1'b0, 0);

    // Re-arm: timer held high through DONE must not start a second clip
    do_record(1'b1, CLIP_LEN, 1, 1, 0);
    for (int c = 0; c < 6; c++) begin
      rx_valid = 1; rx_data = 16'($urandom);
      step();
      chk("rearm_busy", busy, 0);
    end
    release_cmd();
    do_record(1'b1, CLIP_LEN, 0, 2, 0);
    do_play(1'b1, -1);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) do_record(1'($urandom), CLIP_LEN, 0, 3, 0);
      else do_play(1'($urandom), -1);
    end

    // Asynchronous reset while a sample is on offer
    memoryselect_clip_1 = 2'b00; seriena = 1; deseriena = 0; timer = 1; tx_ready = 0;
    exp_tx.push_back(ref_mem[16'h0000]);
    begin
      int cyc = 0;
      while (!tx_valid && cyc < 10) begin
        step();
        cyc++;
      end
    end
    chk("rst_mid_tx_valid_seen", tx_valid, 1);
    #2;
    reset = 1;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_seconds2", seconds2, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    exp_tx.delete();
    timer = 0; seriena = 0;
    step();
    reset = 0;
    step();
    do_record(1'b0, CLIP_LEN, 0, 1, 0);
    do_play(1'b0, 2);

    repeat (3) step();
    chk("writes_left", exp_wr.size(), 0);
    chk("tx_left", exp_tx.size(), 0);
    chk("done_left", done_pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
